// File: rtl/mem_arbiter_if.sv
// Bundle of fetch/data request ports and the shared memory command port.
// No logic; wiring only, zero latency.
// Backpressure is the held-request/ack protocol on the requesters and mem_ready on memory.
interface mem_arbiter_if;
   // fetch requester
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_ack;
   logic [31:0] i_rdata;
   // data requester
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [1:0]  d_size;
   logic [31:0] d_wdata;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        err;
   // memory port
   logic        mem_rd;
   logic        mem_wr;
   logic [31:0] mem_addr;
   logic [1:0]  mem_size;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   // arbiter side
   modport master (
      input  i_req, i_addr, d_req, d_we, d_addr, d_size, d_wdata, mem_rdata, mem_ready,
      output i_ack, i_rdata, d_ack, d_rdata, err,
             mem_rd, mem_wr, mem_addr, mem_size, mem_wdata
   );

   // requester/memory side
   modport slave (
      output i_req, i_addr, d_req, d_we, d_addr, d_size, d_wdata, mem_rdata, mem_ready,
      input  i_ack, i_rdata, d_ack, d_rdata, err,
             mem_rd, mem_wr, mem_addr, mem_size, mem_wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving fetch and load/store units one shared memory port.
// Latency: grant -> command -> ack, min 3 cycles; ack k+1 cycles after command start.
// Requests are held until ack; memory stalls via mem_ready, watchdog aborts after TIMEOUT.
module mem_arbiter #(
   parameter int unsigned TIMEOUT = 64
) (
   input logic           clk,
   input logic           rst_n,
   mem_arbiter_if.master bus
);

   localparam logic [15:0] TMO = 16'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state_q;
   state_t      state_nxt;

   logic        owner_q;       // 1 = data unit owns the transaction
   logic        last_grant_q;  // 1 = data unit was granted last
   logic        we_q;
   logic [31:0] addr_q;
   logic [1:0]  size_q;
   logic [31:0] wdata_q;
   logic [31:0] resp_q;
   logic        err_q;
   logic [15:0] timer_q;

   logic        grant_any;
   logic        grant_d;
   logic        tmo_hit;

   assign grant_any = bus.i_req | bus.d_req;
   // On contention the requester that did not win last time goes first.
   assign grant_d   = bus.d_req & (~bus.i_req | ~last_grant_q);
   // Abort on the stalled cycle where TIMEOUT low cycles are already counted,
   // which puts the error ack TIMEOUT+1 cycles after command start.
   // A completion in that same cycle takes priority.
   assign tmo_hit   = (TMO != 16'd0) && (timer_q == TMO) && !bus.mem_ready;

   // State register; async reset drops the command strobes immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_nxt;
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE:    if (grant_any) state_nxt = CMD;
         CMD:     if (bus.mem_ready || tmo_hit) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Command latch on grant, watchdog timer and response capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         we_q         <= 1'b0;
         addr_q       <= 32'd0;
         size_q       <= 2'd0;
         wdata_q      <= 32'd0;
         resp_q       <= 32'd0;
         err_q        <= 1'b0;
         timer_q      <= 16'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_any) begin
                  owner_q      <= grant_d;
                  last_grant_q <= grant_d;
                  timer_q      <= 16'd0;
                  if (grant_d) begin
                     we_q    <= bus.d_we;
                     addr_q  <= bus.d_addr;
                     size_q  <= (bus.d_size == 2'd3) ? 2'd2 : bus.d_size;
                     wdata_q <= bus.d_wdata;
                  end else begin
                     we_q    <= 1'b0;
                     addr_q  <= bus.i_addr;
                     size_q  <= 2'd2;
                     wdata_q <= 32'd0;
                  end
               end
            end
            CMD: begin
               if (bus.mem_ready) begin
                  resp_q <= we_q ? 32'd0 : bus.mem_rdata;
                  err_q  <= 1'b0;
               end else if (tmo_hit) begin
                  resp_q <= 32'd0;
                  err_q  <= 1'b1;
               end else begin
                  timer_q <= timer_q + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Output decode purely from registered state; no input reaches an output.
   always_comb begin
      bus.mem_rd    = (state_q == CMD) && !we_q;
      bus.mem_wr    = (state_q == CMD) &&  we_q;
      bus.mem_addr  = addr_q;
      bus.mem_size  = size_q;
      bus.mem_wdata = wdata_q;
      bus.i_ack     = (state_q == RESP) && !owner_q;
      bus.d_ack     = (state_q == RESP) &&  owner_q;
      bus.i_rdata   = bus.i_ack ? resp_q : 32'd0;
      bus.d_rdata   = bus.d_ack ? resp_q : 32'd0;
      bus.err       = (state_q == RESP) && err_q;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a transaction-level reference model.
// Inputs driven and outputs sampled on the falling clock edge.
// Memory latency per transaction is chosen by the bench; requests are held until ack.
module tb_mem_arbiter;
   localparam int T = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   mem_arbiter_if bus();

   mem_arbiter #(.TIMEOUT(T)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Pending requests as seen by the model
   bit          i_pend, d_pend;
   logic [31:0] i_a, d_a, d_wd;
   logic        d_w;
   logic [1:0]  d_sz;
   bit          last_d;   // 1 = data unit granted last

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic drive_reqs();
      bus.i_req   = i_pend;
      bus.i_addr  = i_a;
      bus.d_req   = d_pend;
      bus.d_we    = d_w;
      bus.d_addr  = d_a;
      bus.d_size  = d_sz;
      bus.d_wdata = d_wd;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_rd"},  32'(bus.mem_rd), 32'd0);
      chk({tag, "_wr"},  32'(bus.mem_wr), 32'd0);
      chk({tag, "_ack"}, 32'({bus.i_ack, bus.d_ack}), 32'd0);
   endtask

   // One transaction from the IDLE falling edge; memory completes k cycles after command start.
   task automatic txn(input int k, input logic [31:0] rd);
      bit          win_d;
      bit          exp_err;
      int          stop;
      logic        e_we;
      logic [31:0] e_addr, e_wd, e_rd;
      logic [1:0]  e_sz;

      win_d  = d_pend && (!i_pend || !last_d);
      last_d = win_d;
      if (win_d) begin
         e_we = d_w; e_addr = d_a; e_wd = d_wd;
         e_sz = (d_sz == 2'd3) ? 2'd2 : d_sz;
      end else begin
         e_we = 1'b0; e_addr = i_a; e_wd = 32'd0; e_sz = 2'd2;
      end
      exp_err = (T != 0) && (k > T);
      stop    = exp_err ? T : k;
      e_rd    = (exp_err || e_we) ? 32'd0 : rd;

      drive_reqs();
      @(negedge clk);
      for (int j = 0; j <= stop; j++) begin
         chk("mem_rd",   32'(bus.mem_rd), 32'(!e_we));
         chk("mem_wr",   32'(bus.mem_wr), 32'(e_we));
         chk("mem_addr", bus.mem_addr, e_addr);
         chk("mem_size", 32'(bus.mem_size), 32'(e_sz));
         if (!win_d || e_we) chk("mem_wdata", bus.mem_wdata, e_wd);
         chk("ack_early", 32'({bus.i_ack, bus.d_ack}), 32'd0);
         bus.mem_ready = (j == k);
         bus.mem_rdata = rd;
         @(negedge clk);
      end
      bus.mem_ready = 1'b0;
      bus.mem_rdata = $urandom;
      chk("i_ack", 32'(bus.i_ack), 32'(!win_d));
      chk("d_ack", 32'(bus.d_ack), 32'(win_d));
      chk("rdata", win_d ? bus.d_rdata : bus.i_rdata, e_rd);
      chk("err", 32'(bus.err), 32'(exp_err));
      chk("resp_strobe", 32'(bus.mem_rd | bus.mem_wr), 32'd0);
      if (win_d) d_pend = 1'b0; else i_pend = 1'b0;
      drive_reqs();
      @(negedge clk);
      chk_quiet("idle");
   endtask

   task automatic new_d(input logic we, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
      d_pend = 1'b1; d_w = we; d_a = a; d_sz = sz; d_wd = wd;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      i_pend = 0; d_pend = 0; i_a = 32'h1234_5678; d_a = 32'hCAFE_0000;
      d_w = 1; d_sz = 2; d_wd = 32'h5555_AAAA; last_d = 1'b1;
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
      i_pend = 1; d_pend = 1;
      drive_reqs();
      repeat (3) @(negedge clk);
      // reset state with busy inputs
      chk("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
      chk("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
      chk("rst_mem_size", 32'(bus.mem_size), 32'd0);
      chk("rst_acks", 32'({bus.i_ack, bus.d_ack}), 32'd0);
      chk("rst_i_rdata", bus.i_rdata, 32'd0);
      chk("rst_d_rdata", bus.d_rdata, 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
      bus.mem_ready = 1'b0;
      i_pend = 0; d_pend = 0;
      drive_reqs();
      rst_n = 1'b1;
      @(negedge clk);
      chk_quiet("post_rst");

      // contention after reset, both held: I, D, I, D
      for (int n = 0; n < 4; n++) begin
         i_pend = 1; i_a = 32'h40 + 32'(n * 4);
         new_d(1'b0, 32'h800 + 32'(n * 4), 2'd2, 32'd0);
         txn(0, $urandom);
      end
      i_pend = 0; d_pend = 0;

      // single fetch
      i_pend = 1; i_a = 32'h100;
      txn(0, 32'hDEADBEEF);
      // store with two wait states
      new_d(1'b1, 32'h2004, 2'd0, 32'hAB);
      txn(2, $urandom);
      // watchdog abort with memory stuck
      new_d(1'b0, 32'h3000, 2'd2, 32'd0);
      txn(100, 32'h1111_2222);
      // completion on the abort cycle wins
      new_d(1'b0, 32'h3004, 2'd1, 32'd0);
      txn(T, 32'h3333_4444);
      i_pend = 1; i_a = 32'h200;
      txn(T, 32'h5555_6666);

      // async reset in the middle of a command
      i_pend = 1; i_a = 32'h500;
      new_d(1'b1, 32'h600, 2'd2, 32'h77);
      drive_reqs();
      @(negedge clk);
      chk("cmd_before_rst", 32'(bus.mem_rd | bus.mem_wr), 32'd1);
      #2 rst_n = 1'b0;
      #1 chk("rst_strobe_drop", 32'(bus.mem_rd | bus.mem_wr), 32'd0);
      chk("rst_no_ack", 32'({bus.i_ack, bus.d_ack}), 32'd0);
      @(negedge clk);
      chk_quiet("in_rst");
      rst_n = 1'b1;
      last_d = 1'b1;
      txn(1, 32'h0BAD_F00D);   // contention must go to fetch first
      txn(0, $urandom);
      i_pend = 0; d_pend = 0;

      // randomized traffic
      for (int n = 0; n < 200; n++) begin
         int k;
         if (!i_pend && ($urandom_range(0, 1) == 1)) begin
            i_pend = 1; i_a = $urandom;
         end
         if (!d_pend && ($urandom_range(0, 1) == 1))
            new_d(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)), $urandom);
         if (!i_pend && !d_pend) begin
            drive_reqs();
            @(negedge clk);
            chk_quiet("idle_stay");
            continue;
         end
         k = ($urandom_range(0, 4) == 0) ? $urandom_range(T, T + 4) : $urandom_range(0, 3);
         txn(k, $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
